mux_arbiter_32: RTL and testbench
=================================

MUX_ARBITER_32 -- requirements
Module: mux_arbiter_32

Interface
REQ-001 Parameter WIDTH, default 32, data width of each requester and the output.
REQ-002 Parameter BURST, default 4, max consecutive transfers per grant; legal range 1..15.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in0_valid  input  1  requester 0 has data.
REQ-006 in0_data  input  WIDTH  requester 0 payload.
REQ-007 in0_ready  output  1  requester 0 transfer accepted this cycle.
REQ-008 in1_valid  input  1  requester 1 has data.
REQ-009 in1_data  input  WIDTH  requester 1 payload.
REQ-010 in1_ready  output  1  requester 1 transfer accepted this cycle.
REQ-011 sel  output  1  select driven into the internal 2:1 datapath mux; 0 = in0_data, 1 = in1_data.
REQ-012 grant  output  2  one-hot current owner; 2'b00 when idle.
REQ-013 out_valid  output  1  output register holds data.
REQ-014 out_data  output  WIDTH  registered payload.
REQ-015 out_ready  input  1  downstream accepts out_data this cycle.

Function
REQ-016 The payload path SHALL be a WIDTH-bit 2:1 mux steered by sel, feeding a one-entry output register; no data is duplicated or dropped.
REQ-017 FSM states SHALL be IDLE, GNT0, GNT1; grant = 2'b00/2'b01/2'b10 respectively; sel = 1 only in GNT1, else 0.
REQ-018 space = !out_valid | out_ready (combinational from out_ready).
REQ-019 inX_ready SHALL be 1 only when state = GNTX and space = 1; transfer X = inX_valid & inX_ready.
REQ-020 On a transfer the output register SHALL load the selected data and set out_valid next edge.
REQ-021 When out_valid & out_ready and no transfer occurs, out_valid SHALL clear next edge; out_data holds its last value.
REQ-022 IDLE: only in0_valid -> GNT0; only in1_valid -> GNT1; both -> requester other than last_grant; neither -> stay.
REQ-023 A grant decision costs one cycle: no inX_ready is asserted in IDLE.
REQ-024 Minimum latency SHALL be 2 cycles from inX_valid rising in IDLE to out_valid = 1.
REQ-025 burst_cnt (4 bits) SHALL clear on entering GNTx and increment on each transfer.
REQ-026 In GNTX, when a transfer brings burst_cnt to BURST: if the other requester is valid, switch directly to the other GNT state; else stay in GNTX with burst_cnt cleared.
REQ-027 In GNTX, when inX_valid = 0: other requester valid -> other GNT state; else -> IDLE.
REQ-028 last_grant SHALL update to X on every entry into GNTX.
REQ-029 Back-pressure (space = 0) SHALL freeze state and burst_cnt; grant never changes while inX_valid = 1 and burst < BURST.
REQ-030 Simultaneous downstream drain and new transfer in one cycle SHALL sustain one word per cycle.

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE, grant 2'b00, sel 0, in0_ready 0, in1_ready 0, out_valid 0, out_data 0, burst_cnt 0, last_grant 1 (requester 0 wins first tie).
REQ-032 Reset mid-transfer SHALL discard the held output word; operation resumes from IDLE on the first edge after rst_n rises.

Verification
REQ-033 Reset then in0_valid=1, in0_data=32'hAAAAAAAA, out_ready=1 -> grant=01 at cycle 1, out_valid=1 and out_data=32'hAAAAAAAA at cycle 2, sel=0.
REQ-034 Both valid from IDLE after reset, out_ready=1, BURST=4 -> four in0 words, then sel=1 and four in1 words, alternating; no idle cycles after the first grant.
REQ-035 GNT1 streaming with out_ready=0 for 5 cycles -> out_valid stays 1, out_data stable, in1_ready=0, grant stays 10; resumes on out_ready=1 without loss.
REQ-036 in0 alone for 10 words, BURST=4 -> grant stays 01 throughout, burst_cnt wraps at 4.
REQ-037 in1 data 32'h55555555 held in output, rst_n pulsed low mid-cycle -> out_valid, grant, readies 0 immediately; next tie grants in0.

Source files
------------

// File: rtl/mux_arbiter_32.sv
// Two-requester arbiter with bounded bursts, a 2:1 payload mux and a one-entry
// output register. Ties from idle go to the requester that was not granted last.
module mux_arbiter_32 #(
    parameter int WIDTH = 32,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             sel,
    output logic [1:0]       grant,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [3:0] BURST_MAX = 4'(BURST);

    state_t           state_reg, state_next;
    logic [3:0]       burst_cnt_reg, burst_cnt_next;
    logic             last_grant_reg, last_grant_next;
    logic             out_valid_reg, out_valid_next;
    logic [WIDTH-1:0] out_data_reg, out_data_next;

    logic             space;
    logic             xfer0, xfer1, xfer;
    logic             own_valid, other_valid;
    logic [3:0]       cnt_inc;
    logic [WIDTH-1:0] mux_data;

    // Output register can take a word if empty or being drained this cycle.
    assign space = !out_valid_reg || out_ready;

    assign sel       = (state_reg == GNT1);
    assign grant     = {state_reg == GNT1, state_reg == GNT0};
    assign in0_ready = (state_reg == GNT0) && space;
    assign in1_ready = (state_reg == GNT1) && space;

    assign xfer0 = in0_valid && in0_ready;
    assign xfer1 = in1_valid && in1_ready;
    assign xfer  = xfer0 || xfer1;

    assign cnt_inc = burst_cnt_reg + 4'd1;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mux
            assign mux_data[gi] = sel ? in1_data[gi] : in0_data[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            burst_cnt_reg  <= 4'd0;
            last_grant_reg <= 1'b1;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            burst_cnt_reg  <= burst_cnt_next;
            last_grant_reg <= last_grant_next;
            out_valid_reg  <= out_valid_next;
            out_data_reg   <= out_data_next;
        end
    end

    always_comb begin
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        if (xfer) begin
            out_valid_next = 1'b1;
            out_data_next  = mux_data;
        end else if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_comb begin
        state_next      = state_reg;
        burst_cnt_next  = burst_cnt_reg;
        last_grant_next = last_grant_reg;
        own_valid       = (state_reg == GNT1) ? in1_valid : in0_valid;
        other_valid     = (state_reg == GNT1) ? in0_valid : in1_valid;

        case (state_reg)
            IDLE: begin
                // last_grant_reg = 1 means requester 1 went last, so 0 wins a tie
                if (in0_valid && (!in1_valid || last_grant_reg)) begin
                    state_next      = GNT0;
                    burst_cnt_next  = 4'd0;
                    last_grant_next = 1'b0;
                end else if (in1_valid) begin
                    state_next      = GNT1;
                    burst_cnt_next  = 4'd0;
                    last_grant_next = 1'b1;
                end
            end
            GNT0, GNT1: begin
                if (space) begin
                    if (!own_valid) begin
                        burst_cnt_next = 4'd0;
                        if (other_valid) begin
                            state_next      = (state_reg == GNT0) ? GNT1 : GNT0;
                            last_grant_next = (state_reg == GNT0);
                        end else begin
                            state_next = IDLE;
                        end
                    end else if (cnt_inc == BURST_MAX) begin
                        burst_cnt_next = 4'd0;
                        if (other_valid) begin
                            state_next      = (state_reg == GNT0) ? GNT1 : GNT0;
                            last_grant_next = (state_reg == GNT0);
                        end
                    end else begin
                        burst_cnt_next = cnt_inc;
                    end
                end
            end
            default: begin
                state_next     = IDLE;
                burst_cnt_next = 4'd0;
            end
        endcase
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

endmodule

// File: tb/tb_mux_arbiter_32.sv
// Randomised and directed bench for mux_arbiter_32 against a transaction-level
// model of ownership, burst length and the output register.
module tb_mux_arbiter_32;

    localparam int WIDTH = 32;
    localparam int BURST = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in0_valid, in1_valid;
    logic [WIDTH-1:0] in0_data, in1_data;
    logic             in0_ready, in1_ready;
    logic             sel;
    logic [1:0]       grant;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    int total = 0;
    int bad   = 0;

    // model: owner -1 = nobody, run = words in current burst
    int               m_owner;
    int               m_run;
    int               m_last;
    bit               m_ov;
    logic [WIDTH-1:0] m_od;
    bit               acc [2];

    mux_arbiter_32 #(.WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .sel       (sel),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_run   = 0;
        m_last  = 1;
        m_ov    = 0;
        m_od    = '0;
        acc[0]  = 0;
        acc[1]  = 0;
    endtask

    task automatic model_grant(input int who);
        m_owner = who;
        m_run   = 0;
        m_last  = who;
    endtask

    task automatic check_outputs();
        logic [1:0] eg;
        bit sp;
        eg = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
        sp = !m_ov || out_ready;
        check_val("grant", grant, eg);
        check_val("sel", sel, m_owner == 1);
        check_val("in0_ready", in0_ready, (m_owner == 0) && sp);
        check_val("in1_ready", in1_ready, (m_owner == 1) && sp);
        check_val("out_valid", out_valid, m_ov);
        check_val("out_data", out_data, m_od);
    endtask

    task automatic model_step();
        bit v [2];
        logic [WIDTH-1:0] d [2];
        bit sp;
        int t, o;
        v[0] = in0_valid; v[1] = in1_valid;
        d[0] = in0_data;  d[1] = in1_data;
        sp = !m_ov || out_ready;
        t  = (m_owner >= 0 && sp && v[m_owner]) ? m_owner : -1;
        acc[0] = (t == 0);
        acc[1] = (t == 1);
        if (t >= 0) begin
            m_ov = 1;
            m_od = d[t];
        end else if (m_ov && out_ready) begin
            m_ov = 0;
        end
        if (m_owner < 0) begin
            if (v[0] && v[1]) model_grant(m_last == 0 ? 1 : 0);
            else if (v[0])    model_grant(0);
            else if (v[1])    model_grant(1);
        end else if (sp) begin
            o = 1 - m_owner;
            if (!v[m_owner]) begin
                if (v[o]) model_grant(o);
                else      m_owner = -1;
            end else begin
                m_run++;
                if (m_run == BURST) begin
                    if (v[o]) model_grant(o);
                    else      m_run = 0;
                end
            end
        end
    endtask

    // Inputs are already driven; check, advance the model, then cross one edge.
    task automatic run_cycle();
        #1;
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // mode 0 random, 1 both streaming, 2 in0 only, 3 in1 only
    task automatic drive_next(input int mode, input bit ordy);
        case (mode)
            0: begin
                if (acc[0] || !in0_valid) begin
                    in0_valid = ($urandom_range(0, 99) < 60);
                    in0_data  = $urandom;
                end
                if (acc[1] || !in1_valid) begin
                    in1_valid = ($urandom_range(0, 99) < 60);
                    in1_data  = $urandom;
                end
                out_ready = ($urandom_range(0, 99) < 70);
            end
            1: begin
                in0_valid = 1; in1_valid = 1;
                if (acc[0]) in0_data = $urandom;
                if (acc[1]) in1_data = $urandom;
                out_ready = ordy;
            end
            2: begin
                in0_valid = 1; in1_valid = 0;
                if (acc[0]) in0_data = $urandom;
                out_ready = ordy;
            end
            default: begin
                in0_valid = 0; in1_valid = 1;
                if (acc[1]) in1_data = $urandom;
                out_ready = ordy;
            end
        endcase
    endtask

    task automatic do_reset();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        in0_valid = 0; in1_valid = 0;
        in0_data = '0; in1_data = '0;
        out_ready = 0;
        model_reset();
        #3;
        check_outputs();
        do_reset();

        // single requester, minimum latency
        in0_valid = 1; in0_data = 32'hAAAAAAAA; out_ready = 1;
        run_cycle();
        check_val("lat_grant_c1", grant, 2'b01);
        check_val("lat_ready_c1", in0_ready, 1'b1);
        run_cycle();
        check_val("lat_valid_c2", out_valid, 1'b1);
        check_val("lat_data_c2", out_data, 32'hAAAAAAAA);
        check_val("lat_sel_c2", sel, 1'b0);

        // both streaming: alternating bursts, one word per cycle
        in0_valid = 0;
        do_reset();
        in0_valid = 1; in1_valid = 1;
        in0_data = $urandom; in1_data = $urandom; out_ready = 1;
        for (int i = 0; i < 20; i++) begin
            run_cycle();
            if (i >= 1) check_val("stream_no_gap", in0_ready | in1_ready, 1'b1);
            drive_next(1, 1'b1);
        end

        // in0 alone for several bursts
        for (int i = 0; i < 12; i++) begin
            run_cycle();
            drive_next(2, 1'b1);
        end

        // in1 streaming with a 5-cycle stall
        for (int i = 0; i < 16; i++) begin
            run_cycle();
            drive_next(3, !(i >= 4 && i < 9));
        end

        // random traffic
        for (int i = 0; i < 2500; i++) begin
            run_cycle();
            drive_next(0, 1'b0);
        end

        // reset while an in1 word is held in the output register
        in0_valid = 0; in1_valid = 0; out_ready = 0;
        do_reset();
        in1_valid = 1; in1_data = 32'h55555555;
        for (int i = 0; i < 3; i++) run_cycle();
        check_val("held_data", out_data, 32'h55555555);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_grant", grant, 2'b00);
        check_val("rst_in1_ready", in1_ready, 1'b0);
        check_outputs();
        @(negedge clk);
        rst_n = 1;
        in0_valid = 1; in0_data = $urandom; out_ready = 1;
        run_cycle();
        check_val("tie_after_rst", grant, 2'b01);
        for (int i = 0; i < 10; i++) begin
            run_cycle();
            drive_next(1, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
